spi_send: RTL and testbench



---
 rtl/spi_send.sv | 140 ++++++++++++++
 tb/tb_spi_send.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_send.sv
// SPI mode-0 slave transmitter (MISO) with a TX FIFO; all SPI pins oversampled in sys_clk.
// Optional SPI_SEND_LSB_FIRST_EN: shift out LSB-first instead of MSB-first.
`timescale 1ns/1ps
module spi_send #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  IDLE_BYTE  = 8'hFF
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         spi_clk,
    input  logic                         spi_cs_n,
    output logic                         spi_miso,
    output logic                         spi_miso_oe,
    input  logic                         fifo_wr_en,
    input  logic [7:0]                   fifo_wr_data,
    output logic                         fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         tx_done,
    output logic                         underrun
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t        state, state_d;
    logic [2:0]    sck_sync, cs_sync;
    logic          sck_rise, sck_fall, cs_rise, cs_fall;
    logic [7:0]    shreg, shreg_d, shreg_shifted;
    logic [3:0]    bitcnt, bitcnt_d;
    logic          miso_d, tx_done_d, underrun_d;
    logic          pop, push_ok;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [CW-1:0] count_d;
    logic [7:0]    mem [FIFO_DEPTH];

    // Edge strobes from the third synchroniser stage
    assign sck_rise =  sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] &  sck_sync[2];
    assign cs_fall  = ~cs_sync[1]  &  cs_sync[2];
    assign cs_rise  =  cs_sync[1]  & ~cs_sync[2];

`ifdef SPI_SEND_LSB_FIRST_EN
    assign shreg_shifted = {1'b0, shreg[7:1]};
    assign miso_d        = shreg_d[0];
`else
    assign shreg_shifted = {shreg[6:0], 1'b0};
    assign miso_d        = shreg_d[7];
`endif

    // Next-state and datapath control
    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bitcnt_d   = bitcnt;
        tx_done_d  = 1'b0;
        underrun_d = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) state_d = LOAD;
            end
            LOAD: begin
                bitcnt_d = 4'd0;
                if (fifo_count != CW'(0)) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr[AW-1:0]];
                end else begin
                    shreg_d    = IDLE_BYTE;
                    underrun_d = 1'b1;
                end
                state_d = cs_rise ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (sck_rise) bitcnt_d = bitcnt + 4'd1;
                if (sck_fall) begin
                    if (bitcnt == 4'd8) begin
                        tx_done_d = 1'b1;
                        state_d   = LOAD;
                    end else begin
                        shreg_d = shreg_shifted;
                    end
                end
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop frees the slot first, so push+pop while full is accepted
    assign push_ok = fifo_wr_en & (~fifo_full | pop);

    always_comb begin
        count_d = fifo_count;
        case ({push_ok, pop})
            2'b10:   count_d = fifo_count + CW'(1);
            2'b01:   count_d = fifo_count - CW'(1);
            default: count_d = fifo_count;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            sck_sync    <= 3'b000;
            cs_sync     <= 3'b111;
            shreg       <= 8'h00;
            bitcnt      <= 4'd0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            tx_done     <= 1'b0;
            underrun    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            fifo_full   <= 1'b0;
        end else begin
            state       <= state_d;
            sck_sync    <= {sck_sync[1:0], spi_clk};
            cs_sync     <= {cs_sync[1:0], spi_cs_n};
            shreg       <= shreg_d;
            bitcnt      <= bitcnt_d;
            spi_miso_oe <= (state_d != IDLE);
            if (state_d == SHIFT) spi_miso <= miso_d;
            tx_done     <= tx_done_d;
            underrun    <= underrun_d;
            if (push_ok) wr_ptr <= wr_ptr + CW'(1);
            if (pop)     rd_ptr <= rd_ptr + CW'(1);
            fifo_count  <= count_d;
            fifo_full   <= (count_d == CW'(FIFO_DEPTH));
        end
    end

    // Storage array is not reset; pointers define validity
    always_ff @(posedge sys_clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= fifo_wr_data;
    end

endmodule

// File: tb/tb_spi_send.sv
// Self-checking bench for spi_send: drives a mode-0 SPI master at f_sys/10 with a byte scoreboard.
`timescale 1ns/1ps
module tb_spi_send;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_miso, spi_miso_oe;
    logic       fifo_wr_en = 1'b0;
    logic [7:0] fifo_wr_data = 8'h00;
    logic       fifo_full;
    logic [4:0] fifo_count;
    logic       tx_done, underrun;

    int n_tests = 0;
    int n_fail  = 0;
    int n_tx    = 0;
    int n_ur    = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];

    spi_send #(.FIFO_DEPTH(16), .IDLE_BYTE(8'hFF)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .fifo_count(fifo_count),
        .tx_done(tx_done), .underrun(underrun)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (tx_done)  n_tx++;
        if (underrun) n_ur++;
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge sys_clk);
        fifo_wr_en   = 1'b1;
        fifo_wr_data = b;
        if (model_q.size() < 16) model_q.push_back(b);
        @(negedge sys_clk);
        fifo_wr_en = 1'b0;
    endtask

    // Full frame; CS rises together with the last falling SCK edge
    task automatic xfer_frame(input int nbytes, input bit push_in_load, input logic [7:0] pdata);
        logic [7:0] rx;
        logic [7:0] exp_b;
        spi_cs_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            fifo_wr_en   = push_in_load;
            fifo_wr_data = pdata;
        end
        fifo_wr_en = 1'b0;
        for (int b = 0; b < nbytes; b++) begin
            if (b == 0 && push_in_load) begin
                exp_q.push_back(model_q.pop_front());
                model_q.push_back(pdata);
            end else if (model_q.size() > 0) begin
                exp_q.push_back(model_q.pop_front());
            end else begin
                exp_q.push_back(8'hFF);
            end
            rx = 8'h00;
            for (int k = 0; k < 8; k++) begin
                repeat (5) @(negedge sys_clk);
                rx = {rx[6:0], spi_miso};
                spi_clk = 1'b1;
                repeat (5) @(negedge sys_clk);
                spi_clk = 1'b0;
                if (b == nbytes - 1 && k == 7) spi_cs_n = 1'b1;
            end
            exp_b = exp_q.pop_front();
            n_tests++;
            if (rx !== exp_b) begin
                n_fail++;
                $display("FAIL rx_byte%0d: got %02h expected %02h", b, rx, exp_b);
            end
        end
        repeat (6) @(negedge sys_clk);
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        n_tests += 6;
        if (spi_miso !== 1'b0)    begin n_fail++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
        if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", spi_miso_oe); end
        if (fifo_full !== 1'b0)   begin n_fail++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
        if (fifo_count !== 5'd0)  begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        if (tx_done !== 1'b0)     begin n_fail++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
        if (underrun !== 1'b0)    begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_single;
        int tx0, ur0;
        push_byte(8'hA5);
        n_tests++;
        if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL single_count_push: got %0d expected 1", fifo_count); end
        tx0 = n_tx; ur0 = n_ur;
        xfer_frame(1, 1'b0, 8'h00);
        n_tests += 4;
        if (n_tx - tx0 !== 1) begin n_fail++; $display("FAIL single_tx_done: got %0d pulses expected 1", n_tx - tx0); end
        if (n_ur - ur0 !== 0) begin n_fail++; $display("FAIL single_underrun: got %0d pulses expected 0", n_ur - ur0); end
        if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL single_count_end: got %0d expected 0", fifo_count); end
        if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL single_oe_idle: got %b expected 0", spi_miso_oe); end
    endtask

    task automatic test_underrun;
        int tx0, ur0;
        tx0 = n_tx; ur0 = n_ur;
        xfer_frame(1, 1'b0, 8'h00);
        n_tests += 3;
        if (n_ur - ur0 !== 1) begin n_fail++; $display("FAIL empty_underrun: got %0d pulses expected 1", n_ur - ur0); end
        if (n_tx - tx0 !== 1) begin n_fail++; $display("FAIL empty_tx_done: got %0d pulses expected 1", n_tx - tx0); end
        if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL empty_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_back_to_back;
        int tx0, ur0;
        push_byte(8'h3C);
        push_byte(8'hC3);
        push_byte(8'h5A);
        n_tests++;
        if (fifo_count !== 5'd3) begin n_fail++; $display("FAIL burst_count_push: got %0d expected 3", fifo_count); end
        tx0 = n_tx; ur0 = n_ur;
        xfer_frame(3, 1'b0, 8'h00);
        n_tests += 3;
        if (n_tx - tx0 !== 3) begin n_fail++; $display("FAIL burst_tx_done: got %0d pulses expected 3", n_tx - tx0); end
        if (n_ur - ur0 !== 0) begin n_fail++; $display("FAIL burst_underrun: got %0d pulses expected 0", n_ur - ur0); end
        if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL burst_count_end: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 17; i++) begin
            push_byte(8'(8'h10 + i));
            if (i == 15) begin
                n_tests++;
                if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL fill_full16: got %b expected 1", fifo_full); end
            end
        end
        n_tests += 2;
        if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL fill_count17: got %0d expected 16", fifo_count); end
        if (fifo_full !== 1'b1)   begin n_fail++; $display("FAIL fill_full17: got %b expected 1", fifo_full); end
        // Push held across the LOAD cycle: only the push paired with the pop lands
        xfer_frame(1, 1'b1, 8'h99);
        n_tests++;
        if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL fill_push_pop: got %0d expected 16", fifo_count); end
        xfer_frame(16, 1'b0, 8'h00);
        n_tests += 2;
        if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL fill_drain_count: got %0d expected 0", fifo_count); end
        if (fifo_full !== 1'b0)  begin n_fail++; $display("FAIL fill_drain_full: got %b expected 0", fifo_full); end
    endtask

    task automatic test_abort;
        int tx0;
        logic [3:0] rx4;
        push_byte(8'h81);
        push_byte(8'h7E);
        void'(model_q.pop_front());
        tx0 = n_tx;
        rx4 = 4'h0;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge sys_clk);
        n_tests++;
        if (spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL abort_oe_active: got %b expected 1", spi_miso_oe); end
        for (int k = 0; k < 4; k++) begin
            repeat (5) @(negedge sys_clk);
            rx4 = {rx4[2:0], spi_miso};
            spi_clk = 1'b1;
            repeat (5) @(negedge sys_clk);
            spi_clk = 1'b0;
        end
        repeat (5) @(negedge sys_clk);
        spi_cs_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        n_tests += 3;
        if (rx4 !== 4'h8)         begin n_fail++; $display("FAIL abort_bits: got %h expected 8", rx4); end
        if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL abort_oe: got %b expected 0", spi_miso_oe); end
        if (n_tx - tx0 !== 0)     begin n_fail++; $display("FAIL abort_tx_done: got %0d pulses expected 0", n_tx - tx0); end
        xfer_frame(1, 1'b0, 8'h00);
        n_tests++;
        if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL abort_count_end: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_reset_mid_byte;
        int tx0, ur0;
        push_byte(8'hF0);
        push_byte(8'h0F);
        tx0 = n_tx; ur0 = n_ur;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge sys_clk);
        for (int k = 0; k < 3; k++) begin
            repeat (5) @(negedge sys_clk);
            spi_clk = 1'b1;
            repeat (5) @(negedge sys_clk);
            spi_clk = 1'b0;
        end
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        n_tests += 6;
        if (spi_miso !== 1'b0)    begin n_fail++; $display("FAIL rstmid_miso: got %b expected 0", spi_miso); end
        if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe: got %b expected 0", spi_miso_oe); end
        if (fifo_count !== 5'd0)  begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
        if (fifo_full !== 1'b0)   begin n_fail++; $display("FAIL rstmid_full: got %b expected 0", fifo_full); end
        if (tx_done !== 1'b0)     begin n_fail++; $display("FAIL rstmid_tx_done: got %b expected 0", tx_done); end
        if (underrun !== 1'b0)    begin n_fail++; $display("FAIL rstmid_underrun: got %b expected 0", underrun); end
        spi_cs_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        model_q.delete();
        exp_q.delete();
        repeat (10) @(negedge sys_clk);
        n_tests += 3;
        if (n_tx - tx0 !== 0) begin n_fail++; $display("FAIL rstmid_tx_pulses: got %0d expected 0", n_tx - tx0); end
        if (n_ur - ur0 !== 0) begin n_fail++; $display("FAIL rstmid_ur_pulses: got %0d expected 0", n_ur - ur0); end
        if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe_after: got %b expected 0", spi_miso_oe); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_underrun();
        test_back_to_back();
        test_fill();
        test_abort();
        test_reset_mid_byte();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
